// File: rtl/loader_mem_bridge_if.sv
// Loader / RAM / CPU-side signal bundle for loader_mem_bridge.
// slave is the bridge's view, master is the environment's view.
interface loader_mem_bridge_if #(
    parameter int ADDR = 16,
    parameter int DATA = 8
);
    logic            loader_wr;
    logic            loader_download;
    logic [ADDR-1:0] loader_addr;
    logic [DATA-1:0] loader_data;
    logic [ADDR-1:0] execute_addr;
    logic            execute_enable;
    logic            ram_busy;
    logic            ram_wr;
    logic [ADDR-1:0] ram_addr;
    logic [DATA-1:0] ram_data;
    logic            cpu_hold;
    logic            fifo_overflow;
    logic            cpu_fetch;
    logic            cpu_rd;
    logic            inj_active;
    logic [7:0]      inj_data;

    modport slave (
        input  loader_wr, loader_download, loader_addr, loader_data,
        input  execute_addr, execute_enable, ram_busy,
        input  cpu_fetch, cpu_rd,
        output ram_wr, ram_addr, ram_data, cpu_hold, fifo_overflow,
        output inj_active, inj_data
    );

    modport master (
        output loader_wr, loader_download, loader_addr, loader_data,
        output execute_addr, execute_enable, ram_busy,
        output cpu_fetch, cpu_rd,
        input  ram_wr, ram_addr, ram_data, cpu_hold, fifo_overflow,
        input  inj_active, inj_data
    );
endinterface

// File: rtl/loader_mem_bridge.sv
// Loader byte stream -> RAM write FIFO, Z80 hold, and JP nn exec injection.
// Define LOADER_EXEC_INJECT_EN to build the execute-address injector.
module loader_mem_bridge #(
    parameter int DEPTH = 4,
    parameter int ADDR  = 16,
    parameter int DATA  = 8
) (
    input logic              clock,
    input logic              reset,
    loader_mem_bridge_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int W  = ADDR + DATA;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          drop;
    logic          dl_q;
    logic          dl_rise;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PW+1)'(DEPTH));
    assign pop        = !fifo_empty && !bus.ram_busy;
    // A full FIFO still accepts a byte when the head leaves this cycle.
    assign push       = bus.loader_wr && (!fifo_full || pop);
    assign drop       = bus.loader_wr && fifo_full && !pop;
    assign dl_rise    = bus.loader_download && !dl_q;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr] <= {bus.loader_addr, bus.loader_data};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr              <= '0;
            rptr              <= '0;
            count             <= '0;
            dl_q              <= 1'b0;
            bus.ram_wr        <= 1'b0;
            bus.ram_addr      <= '0;
            bus.ram_data      <= '0;
            bus.cpu_hold      <= 1'b0;
            bus.fifo_overflow <= 1'b0;
        end else begin
            dl_q         <= bus.loader_download;
            bus.cpu_hold <= bus.loader_download | !fifo_empty | bus.ram_wr;
            bus.ram_wr   <= pop;
            if (pop) begin
                {bus.ram_addr, bus.ram_data} <= mem[rptr];
                rptr <= rptr + 1'b1;
            end
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (dl_rise) begin
                bus.fifo_overflow <= 1'b0;
            end
            if (drop) begin
                bus.fifo_overflow <= 1'b1;
            end
        end
    end

`ifdef LOADER_EXEC_INJECT_EN
    typedef enum logic [2:0] {
        INJ_IDLE,
        INJ_ARMED,
        INJ_OP,
        INJ_LO,
        INJ_HI
    } inj_t;

    inj_t            inj;
    logic            exec_pending;
    logic [ADDR-1:0] exec_addr_q;
    logic            inj_locked;

    assign inj_locked = (inj == INJ_OP) || (inj == INJ_LO) || (inj == INJ_HI);

    // Outputs are loaded together with the state so they track it exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            inj            <= INJ_IDLE;
            exec_pending   <= 1'b0;
            exec_addr_q    <= '0;
            bus.inj_active <= 1'b0;
            bus.inj_data   <= '0;
        end else if (dl_rise) begin
            inj            <= INJ_IDLE;
            exec_pending   <= 1'b0;
            bus.inj_active <= 1'b0;
            bus.inj_data   <= '0;
        end else begin
            if (bus.execute_enable && !inj_locked) begin
                exec_addr_q  <= bus.execute_addr;
                exec_pending <= 1'b1;
            end
            unique case (inj)
                INJ_IDLE: begin
                    if (exec_pending) begin
                        inj <= INJ_ARMED;
                    end
                end
                INJ_ARMED: begin
                    if (!bus.cpu_hold && fifo_empty &&
                        !bus.loader_download) begin
                        inj            <= INJ_OP;
                        bus.inj_active <= 1'b1;
                        bus.inj_data   <= 8'hC3;
                    end
                end
                INJ_OP: begin
                    if (bus.cpu_fetch) begin
                        inj          <= INJ_LO;
                        bus.inj_data <= exec_addr_q[7:0];
                    end
                end
                INJ_LO: begin
                    if (bus.cpu_rd) begin
                        inj          <= INJ_HI;
                        bus.inj_data <= exec_addr_q[15:8];
                    end
                end
                INJ_HI: begin
                    if (bus.cpu_rd) begin
                        inj            <= INJ_IDLE;
                        exec_pending   <= 1'b0;
                        bus.inj_active <= 1'b0;
                        bus.inj_data   <= '0;
                    end
                end
                default: begin
                    inj            <= INJ_IDLE;
                    bus.inj_active <= 1'b0;
                    bus.inj_data   <= '0;
                end
            endcase
        end
    end
`else
    logic unused_exec;

    assign unused_exec    = ^{bus.execute_addr, bus.execute_enable,
                              bus.cpu_fetch, bus.cpu_rd};
    assign bus.inj_active = 1'b0;
    assign bus.inj_data   = '0;
`endif
endmodule

// File: tb/tb_loader_mem_bridge.sv
// Randomized + directed bench for loader_mem_bridge against a queue model.
// Injection checks follow LOADER_EXEC_INJECT_EN.
module tb_loader_mem_bridge;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    loader_mem_bridge_if #(.ADDR(16), .DATA(8)) bus ();

    loader_mem_bridge #(
        .DEPTH(DEPTH),
        .ADDR (16),
        .DATA (8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [23:0] q[$];
    logic        m_wr;
    logic        m_hold;
    logic        m_ovf;
    logic        m_dl;
    logic [15:0] m_addr;
    logic [7:0]  m_data;
    logic        e_act;
    logic [7:0]  e_dat;
    logic        inj_chk;
    logic        hold_seen;
    int          nwr;
    logic [15:0] last_addr;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic wr, input logic [15:0] a,
                       input logic [7:0] d, input logic busy,
                       input logic dl);
        int          sz;
        logic        pop;
        logic        hn;
        logic [23:0] e;
        bus.loader_wr       = wr;
        bus.loader_addr     = a;
        bus.loader_data     = d;
        bus.ram_busy        = busy;
        bus.loader_download = dl;
        hold_seen           = bus.cpu_hold;
        sz  = q.size();
        pop = (sz > 0) && !busy;
        hn  = dl || (sz > 0) || m_wr;
        if (dl && !m_dl) m_ovf = 1'b0;
        m_wr = pop;
        if (pop) begin
            e      = q.pop_front();
            m_addr = e[23:8];
            m_data = e[7:0];
        end
        if (wr) begin
            if (sz < DEPTH || pop) q.push_back({a, d});
            else m_ovf = 1'b1;
        end
        m_hold = hn;
        m_dl   = dl;
        @(posedge clock);
        #1;
        bus.execute_enable = 1'b0;
        bus.cpu_fetch      = 1'b0;
        bus.cpu_rd         = 1'b0;
        check("ram_wr", bus.ram_wr, m_wr);
        if (m_wr) begin
            check("ram_addr", bus.ram_addr, m_addr);
            check("ram_data", bus.ram_data, m_data);
        end
        if (bus.ram_wr) begin
            nwr++;
            last_addr = bus.ram_addr;
        end
        check("cpu_hold", bus.cpu_hold, m_hold);
        check("fifo_overflow", bus.fifo_overflow, m_ovf);
        if (inj_chk) begin
            check("inj_active", bus.inj_active, e_act);
            check("inj_data", bus.inj_data, e_dat);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.loader_wr       = 1'b0;
        bus.loader_download = 1'b0;
        bus.ram_busy        = 1'b0;
        @(posedge clock);
        #1;
        q.delete();
        m_wr = 1'b0; m_hold = 1'b0; m_ovf = 1'b0; m_dl = 1'b0;
        check("rst_ram_wr", bus.ram_wr, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_data", bus.ram_data, 0);
        check("rst_hold", bus.cpu_hold, 0);
        check("rst_ovf", bus.fifo_overflow, 0);
        check("rst_inj_act", bus.inj_active, 0);
        check("rst_inj_dat", bus.inj_data, 0);
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rdl;
        bus.loader_wr       = 1'b0;
        bus.loader_download = 1'b0;
        bus.loader_addr     = '0;
        bus.loader_data     = '0;
        bus.execute_addr    = '0;
        bus.execute_enable  = 1'b0;
        bus.ram_busy        = 1'b0;
        bus.cpu_fetch       = 1'b0;
        bus.cpu_rd          = 1'b0;
        inj_chk = 1'b1; e_act = 1'b0; e_dat = 8'h00;
        nwr = 0; last_addr = '0; hold_seen = 1'b0;
        do_reset();

        cyc(1'b1, 16'h4000, 8'h55, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
        check("single_wr", bus.ram_wr, 1);
        check("single_addr", bus.ram_addr, 16'h4000);
        check("single_data", bus.ram_data, 8'h55);
        idle(1);
        check("single_once", bus.ram_wr, 0);

        for (int i = 0; i < 6; i++)
            cyc(1'b1, 16'h1000 + 16'(i), 8'(i), 1'b1, 1'b0);
        check("ovf_set", bus.fifo_overflow, 1);
        nwr = 0;
        idle(8);
        check("ovf_cnt", nwr, 4);
        check("ovf_last", last_addr, 16'h1003);
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 16'h2000 + 16'(i), 8'hA0 + 8'(i), 1'b1, 1'b0);
        nwr = 0;
        idle(8);
        check("wrap_cnt", nwr, 4);
        check("wrap_last", last_addr, 16'h2003);

        cyc(1'b0, 16'h0, 8'h0, 1'b1, 1'b1);
        cyc(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
        check("ovf_clr", bus.fifo_overflow, 0);
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 16'h3000 + 16'(i), 8'(i), 1'b1, 1'b0);
        nwr = 0;
        cyc(1'b1, 16'h3AAA, 8'h77, 1'b0, 1'b0);
        check("pp_ovf", bus.fifo_overflow, 0);
        idle(8);
        check("pp_cnt", nwr, 5);
        check("pp_last", last_addr, 16'h3AAA);

        for (int i = 0; i < 10; i++)
            cyc(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)), 1'b1);
        idle(12);
        check("hold_end", bus.cpu_hold, 0);

        rdl = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) rdl = ~rdl;
            cyc(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                $urandom_range(0, 9) < 3, rdl);
        end
        idle(12);

`ifdef LOADER_EXEC_INJECT_EN
        cyc(1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
        bus.execute_enable = 1'b1;
        bus.execute_addr   = 16'h5200;
        cyc(1'b1, 16'h6000, 8'h11, 1'b0, 1'b1);
        cyc(1'b1, 16'h6001, 8'h22, 1'b1, 1'b1);
        cyc(1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
        inj_chk = 1'b0;
        for (int i = 0; i < 20 && !bus.inj_active; i++) idle(1);
        check("op_act", bus.inj_active, 1);
        check("op_dat", bus.inj_data, 8'hC3);
        check("arm_hold", hold_seen, 0);
        inj_chk = 1'b1; e_act = 1'b1; e_dat = 8'hC3;
        bus.cpu_rd = 1'b1;
        idle(1);
        bus.cpu_fetch = 1'b1; bus.cpu_rd = 1'b1; e_dat = 8'h00;
        idle(1);
        bus.cpu_fetch = 1'b1;
        idle(1);
        bus.cpu_rd = 1'b1; e_dat = 8'h52;
        idle(1);
        bus.cpu_rd = 1'b1; e_act = 1'b0; e_dat = 8'h00;
        idle(1);
        for (int i = 0; i < 6; i++) begin
            bus.cpu_fetch = 1'b1; bus.cpu_rd = 1'b1;
            idle(1);
        end

        for (int i = 0; i < 5; i++)
            cyc(1'b1, 16'h7000 + 16'(i), 8'(i), 1'b1, 1'b0);
        check("ab_ovf_set", bus.fifo_overflow, 1);
        bus.execute_enable = 1'b1;
        bus.execute_addr   = 16'h1234;
        inj_chk = 1'b0;
        idle(1);
        for (int i = 0; i < 20 && !bus.inj_active; i++) idle(1);
        check("ab_op_act", bus.inj_active, 1);
        inj_chk = 1'b1; e_act = 1'b1; e_dat = 8'h34;
        bus.cpu_fetch = 1'b1; bus.cpu_rd = 1'b1;
        idle(1);
        e_act = 1'b0; e_dat = 8'h00;
        cyc(1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
        check("ab_ovf_clr", bus.fifo_overflow, 0);
        idle(3);
        for (int i = 0; i < 4; i++) begin
            bus.cpu_fetch = 1'b1; bus.cpu_rd = 1'b1;
            idle(1);
        end
        check("ab_idle", bus.inj_active, 0);
`else
        bus.execute_enable = 1'b1;
        bus.execute_addr   = 16'h5200;
        idle(8);
        for (int i = 0; i < 6; i++) begin
            bus.cpu_fetch = 1'b1; bus.cpu_rd = 1'b1;
            idle(1);
        end
        check("noinj", bus.inj_active, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/loader_mem_bridge.md
# loader_mem_bridge

Sits directly downstream of the ioctl command loader and turns its byte-write stream into RAM writes. Writes are buffered in a small FIFO and committed only in cycles the RAM port is free, and the Z80 is held while a download is in flight. When the loaded image carries an execute address, the bridge hands it to the CPU by injecting a `JP nn` (C3 lo hi) on the CPU's next opcode fetch after the load completes.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16
- `ADDR`, 16: address width
- `DATA`, 8: data width

Ports:
- `clock` in 1: system clock; everything is on the rising edge
- `reset` in 1: **synchronous, active-high**
- `loader_wr` in 1: one-cycle byte-write strobe from the loader
- `loader_download` in 1: loader download active
- `loader_addr` in ADDR: write address
- `loader_data` in DATA: write data
- `execute_addr` in ADDR: start address
- `execute_enable` in 1: one-cycle execute request
- `ram_busy` in 1: the next cycle's RAM slot is owned by CPU or video
- `ram_wr` out 1: RAM write strobe, one cycle per byte
- `ram_addr` out ADDR: RAM write address
- `ram_data` out DATA: RAM write data
- `cpu_hold` out 1: stall the Z80 (drives WAIT/BUSRQ)
- `fifo_overflow` out 1: sticky; a byte was dropped
- `cpu_fetch` in 1: one-cycle pulse per Z80 M1 opcode read
- `cpu_rd` in 1: one-cycle pulse per Z80 memory read (also high on M1)
- `inj_active` out 1: override the CPU data bus with `inj_data`
- `inj_data` out 8: injected byte

## Operation
- **Reset:** all outputs are 0, the FIFO is empty, the injector is in INJ_IDLE, and `exec_pending` is 0.
- **FIFO push:** `loader_wr` writes `{loader_addr, loader_data}` into the FIFO.
  - If the FIFO is full, the byte is dropped and `fifo_overflow` is set.
  - A push and a pop in the same cycle are both legal; the count is unchanged, and this is allowed even when the FIFO is full.
- **FIFO pop:** when the FIFO is not empty and `ram_busy` is 0, the head entry is popped and registered onto `ram_wr=1`, `ram_addr`, `ram_data` for the next cycle. Otherwise `ram_wr` is 0.
- **Pointers:** read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. A separate count of log2(DEPTH)+1 bits generates full and empty.
- **`cpu_hold`:** registered; equals `loader_download | !fifo_empty | ram_wr`.
- **Rising edge of `loader_download`:**
  - clears `fifo_overflow`;
  - clears `exec_pending`;
  - forces the injector to INJ_IDLE, aborting any partial injection.
- **Execute capture:** `execute_enable` latches `execute_addr` into `exec_addr_q` and sets `exec_pending`. A capture in INJ_OP, INJ_LO or INJ_HI is ignored.
- **Injector FSM:**
  - INJ_IDLE → INJ_ARMED when `exec_pending`.
  - INJ_ARMED → INJ_OP when `cpu_hold`=0, the FIFO is empty and `loader_download`=0. In INJ_ARMED a new capture overwrites the address.
  - INJ_OP → INJ_LO on `cpu_fetch`.
  - INJ_LO → INJ_HI on `cpu_rd`.
  - INJ_HI → INJ_IDLE on `cpu_rd`; this transition clears `exec_pending`.
- **Injector outputs:**
  - INJ_OP: `inj_active`=1, `inj_data`=8'hC3.
  - INJ_LO: `inj_active`=1, `inj_data`=`exec_addr_q[7:0]`.
  - INJ_HI: `inj_active`=1, `inj_data`=`exec_addr_q[15:8]`.
  - All other states: `inj_active`=0, `inj_data`=0.
  - Outputs are registered, so they are stable for the whole read cycle.
- **Read strobes:** in INJ_LO and INJ_HI only `cpu_rd` advances the FSM; `cpu_fetch` alone does not.

## Timing
- **Write latency:** `loader_wr` in cycle N, FIFO empty, `ram_busy`=0 in N+1 → `ram_wr`=1 in N+2.
- **Throughput:** one RAM write per free cycle.
- **Backpressure:** each cycle with `ram_busy`=1 delays the pop by exactly one cycle.
- **`cpu_hold` rise:** rises the cycle after `loader_download` rises.
- **`cpu_hold` fall:** falls the cycle after the last `ram_wr` cycle, provided `loader_download`=0.
- **Injector arming:** INJ_OP is entered no earlier than one cycle after `cpu_hold` is sampled 0.
- **State-change visibility:** each injector state change becomes visible on `inj_*` in the cycle after the triggering strobe.
- **Reset mid-operation:** FIFO contents are discarded, an in-flight `ram_wr` is deasserted the next cycle, and the injector returns to INJ_IDLE.

## Configuration
- `LOADER_EXEC_INJECT_EN` defined: the execute capture logic and injector FSM are built as described.
- `LOADER_EXEC_INJECT_EN` undefined:
  - `execute_enable` and `execute_addr` are ignored, and `cpu_fetch` and `cpu_rd` are unused;
  - `inj_active` and `inj_data` are tied to 0;
  - the FIFO and hold behaviour are unchanged.

## Test plan
- **Single write:** reset, then 1 write (addr 16'h4000, data 8'h55) with `ram_busy`=0 → `ram_wr` is high for exactly one cycle 2 cycles later, with 4000/55.
- **Overflow:** DEPTH=4, `ram_busy`=1 held, 6 consecutive writes → the first 4 are retained, `fifo_overflow`=1. Then release `ram_busy` → exactly 4 `ram_wr` in push order, and the pointers wrap correctly on a further 4 writes.
- **Full push/pop:** FIFO full, with a push and a pop in the same cycle → count stays at 4, no overflow, and the new byte emerges last.
- **Hold:** `loader_download` held high for 10 cycles with writes → `cpu_hold` stays high until 1 cycle after the final `ram_wr`.
- **Injection:** `execute_enable` with 16'h5200 during a download, then the download ends and the FIFO drains.
  - The next `cpu_fetch` sees C3; the two following `cpu_rd` see 00 then 52; then `inj_active`=0.
  - With the macro undefined, `inj_active` stays 0 throughout.
- **Abort:** a new `loader_download` rising edge while in INJ_LO → the injector goes to INJ_IDLE, `exec_pending`=0, and `fifo_overflow` is cleared.
